// File: rtl/assoc_tag_lookup.sv
`timescale 1ns/1ps
// assoc_tag_lookup
// N-way set-associative tag store and hit detector for the data cache.
// Holds per-set tags and valid bits, registers the lookup result one cycle
// after the request, reports a one-hot hit vector plus a refill victim way,
// keeps per-set replacement state and runs a SETS-cycle flush that
// invalidates every line.
//
// Optional feature macro: HIT_LRU_EN
//   defined   -> true LRU replacement (WAY_W-bit age per way per set)
//   undefined -> round-robin replacement (WAY_W-bit pointer per set)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_lookup_valid lookup request this cycle
//   i_lookup_idx   set index of the lookup
//   i_lookup_tag   tag to compare
//   o_hit_valid    registered: lookup result valid this cycle
//   o_hit          registered: OR of o_hit_way
//   o_hit_way      registered: one-hot lowest matching way
//   o_victim_way   registered: refill way for the looked-up set
//   i_fill_valid   write a tag into a way (sets its valid bit)
//   i_fill_idx     set to fill
//   i_fill_way     way to fill
//   i_fill_tag     tag written
//   i_flush        pulse: start invalidation of all sets
//   o_busy         flush in progress; lookups and fills are ignored
module assoc_tag_lookup #(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int TAG_W = 28,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lookup_valid,
  input  logic [IDX_W-1:0] i_lookup_idx,
  input  logic [TAG_W-1:0] i_lookup_tag,
  output logic             o_hit_valid,
  output logic             o_hit,
  output logic [WAYS-1:0]  o_hit_way,
  output logic [WAY_W-1:0] o_victim_way,
  input  logic             i_fill_valid,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic [WAY_W-1:0] i_fill_way,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic             i_flush,
  output logic             o_busy
);

  typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_cnt, w_cnt_next;

  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];

  logic             r_hit_valid;
  logic             r_hit;
  logic [WAYS-1:0]  r_hit_way;
  logic [WAY_W-1:0] r_victim_way;

  logic             w_lookup_acc;
  logic             w_fill_acc;
  logic             w_same_set;
  logic [WAYS-1:0]  w_set_valid;
  logic [WAYS-1:0]  w_match;
  logic [WAYS-1:0]  w_hit_way;
  logic             w_any_inval;
  logic [WAY_W-1:0] w_inval_idx;
  logic [WAY_W-1:0] w_repl_idx;
  logic [WAY_W-1:0] w_victim;

  // ---------------- flush FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == IDX_W'(SETS - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_busy       = (r_state == ST_FLUSH);
  assign w_lookup_acc = i_lookup_valid & (r_state == ST_IDLE);
  assign w_fill_acc   = i_fill_valid & (r_state == ST_IDLE);
  assign w_same_set   = w_fill_acc & (i_fill_idx == i_lookup_idx);

  // ---------------- match / victim ----------------
  // All reads happen before the edge, so a same-cycle fill is not visible
  // to the lookup (read before write).
  assign w_set_valid = r_valid[i_lookup_idx];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign w_match[gi] = w_set_valid[gi] & (r_tag[i_lookup_idx][gi] == i_lookup_tag);
  end

  // Isolate the lowest set bit so duplicate tags still yield a one-hot vector.
  assign w_hit_way = w_match & (~w_match + 1'b1);

  // Lowest-index invalid way; scanned high to low so the lowest wins.
  always_comb begin
    w_any_inval = 1'b0;
    w_inval_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!w_set_valid[i]) begin
        w_any_inval = 1'b1;
        w_inval_idx = WAY_W'(i);
      end
    end
  end

  assign w_victim = w_any_inval ? w_inval_idx : w_repl_idx;

  // ---------------- tag / valid storage ----------------
  always_ff @(posedge clk) begin
    if (w_fill_acc) begin
      r_tag[i_fill_idx][i_fill_way] <= i_fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (r_state == ST_FLUSH) begin
      r_valid[r_cnt] <= '0;
    end else if (w_fill_acc) begin
      r_valid[i_fill_idx][i_fill_way] <= 1'b1;
    end
  end

  // ---------------- replacement state ----------------
`ifdef HIT_LRU_EN
  typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  age_vec_t         r_age [SETS];
  age_vec_t         w_age_set;
  logic [WAY_W-1:0] w_hit_idx;
  logic             w_hit_upd;

  function automatic age_vec_t age_init();
    age_vec_t res;
    for (int i = 0; i < WAYS; i++) begin
      res[i] = WAY_W'(i);
    end
    return res;
  endfunction

  // Mark way w most-recently-used: younger ways age by one, w becomes 0.
  function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [WAY_W-1:0] w);
    age_vec_t res;
    res = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (ages[i] < ages[w]) begin
        res[i] = ages[i] + 1'b1;
      end
    end
    res[w] = '0;
    return res;
  endfunction

  assign w_age_set = r_age[i_lookup_idx];

  always_comb begin
    w_repl_idx = '0;
    w_hit_idx  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_age_set[i] == AGE_MAX) w_repl_idx = WAY_W'(i);
      if (w_hit_way[i])            w_hit_idx  = WAY_W'(i);
    end
  end

  // A fill to the same set wins; the hit update is dropped in that case.
  assign w_hit_upd = w_lookup_acc & (|w_match) & ~w_same_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_age[s] <= age_init();
      end
    end else if (r_state == ST_FLUSH) begin
      r_age[r_cnt] <= age_init();
    end else begin
      if (w_fill_acc) begin
        r_age[i_fill_idx] <= lru_touch(r_age[i_fill_idx], i_fill_way);
      end
      if (w_hit_upd) begin
        r_age[i_lookup_idx] <= lru_touch(w_age_set, w_hit_idx);
      end
    end
  end
`else
  logic [WAY_W-1:0] r_ptr [SETS];

  assign w_repl_idx = r_ptr[i_lookup_idx];

  // Pointer advances on fills only; WAYS is a power of two so it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (r_state == ST_FLUSH) begin
      r_ptr[r_cnt] <= '0;
    end else if (w_fill_acc) begin
      r_ptr[i_fill_idx] <= r_ptr[i_fill_idx] + 1'b1;
    end
  end
`endif

  // ---------------- registered result ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_way    <= '0;
      r_victim_way <= '0;
    end else begin
      r_hit_valid <= w_lookup_acc;
      r_hit       <= w_lookup_acc & (|w_match);
      r_hit_way   <= w_lookup_acc ? w_hit_way : '0;
      if (w_lookup_acc) begin
        r_victim_way <= w_victim;
      end
    end
  end

  assign o_hit_valid  = r_hit_valid;
  assign o_hit        = r_hit;
  assign o_hit_way    = r_hit_way;
  assign o_victim_way = r_victim_way;

endmodule

// File: doc/assoc_tag_lookup.md
# assoc_tag_lookup

Parametrised N-way set-associative tag store and hit detector for the data cache. It holds per-set tags and valid bits, registers a lookup result one cycle after request, and reports a one-hot hit vector together with a victim way for refill. It also keeps per-set replacement state and runs a multi-cycle flush that invalidates every line. It sits between the cache controller FSM and the data RAM way-select mux.

## Interface
- WAYS, 4: associativity; power of two, 2..8.
- SETS, 16: number of sets; power of two, ≥2.
- TAG_W, 28: tag width.
- IDX_W, $clog2(SETS): set index width.
- WAY_W, $clog2(WAYS): way index width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_idx  in  IDX_W  set index of the lookup.
- lookup_tag  in  TAG_W  tag to compare.
- hit_valid  out  1  registered; the lookup result is valid this cycle.
- hit  out  1  registered; OR of hit_way.
- hit_way  out  WAYS  registered; one-hot matching way.
- victim_way  out  WAY_W  registered; refill way for the looked-up set.
- fill_valid  in  1  write tag into a way.
- fill_idx  in  IDX_W  set to fill.
- fill_way  in  WAY_W  way to fill.
- fill_tag  in  TAG_W  tag written; the valid bit is set.
- flush  in  1  pulse; starts invalidation of all sets.
- busy  out  1  flush in progress; lookups and fills are ignored.

## Operation
- Storage: tag[SETS][WAYS], valid[SETS][WAYS], and replacement state per set.
- Match: match[i] = valid[idx][i] & (tag[idx][i] == lookup_tag). Each way is checked against its own valid bit.
- Multiple matches: only the lowest-index match is reported in hit_way, so the vector stays one-hot.
- Victim selection:
  - If the set has an invalid way, the victim is the lowest-index invalid way.
  - Otherwise, the victim comes from the replacement policy (see Configuration).
- Fill: at the clock edge, writes tag[fill_idx][fill_way] = fill_tag, sets valid = 1, and marks the way most-recently-used.
- Hit update: a lookup that hits marks hit_way most-recently-used in lookup_idx, on the same edge that registers the result.
- FSM states:
  - IDLE. Goes to FLUSH when flush=1.
  - FLUSH. A set counter runs 0..SETS-1; each cycle it clears valid[cnt][*] and resets the replacement state of that set. After cnt = SETS-1 the FSM returns to IDLE.
- busy = (state == FLUSH).
- A flush pulse while busy is ignored.
- Reset: all valid bits 0, replacement state reset, state IDLE, counter 0.
- Reset output values: hit_valid=0, hit=0, hit_way=0, victim_way=0, busy=0.
- Reset asserted mid-flush aborts the flush to IDLE, with all valid bits 0.

## Timing
- Lookup latency is 1 cycle: the request at edge N gives its result during cycle N+1. Full throughput, one lookup per cycle.
- hit_valid is 0 in every cycle not preceded by an accepted lookup.
- Lookup and fill in the same cycle, same set:
  - The lookup sees the pre-fill contents (read before write).
  - Replacement state takes the fill update only; the hit update is dropped.
- Lookup and fill in the same cycle, different sets: both take effect.
- A flush request at edge N: busy=1 from cycle N+1 for exactly SETS cycles.
- lookup_valid or fill_valid while busy: no effect, and hit_valid=0 the next cycle.
- A lookup accepted in the same cycle flush is sampled completes normally from pre-flush contents.

## Configuration
- HIT_LRU_EN defined: true LRU.
  - Each way keeps a WAY_W-bit age per set; reset/flush ages are age[i]=i.
  - On an access to way w, ways with age < age[w] increment, and age[w]=0.
  - With all ways valid, the victim is the way with age WAYS-1.
- HIT_LRU_EN undefined: round-robin replacement.
  - A per-set WAY_W pointer resets to 0.
  - With all ways valid, the victim is the pointer value.
  - The pointer increments modulo WAYS on each fill to that set; hits do not change it.

## Test plan
- Reset, then lookup idx=3 tag=0xABC. Next cycle: hit_valid=1, hit=0, hit_way=0, victim_way=0.
- Fill idx=3 way=2 tag=0xABC, then lookup idx=3 tag=0xABC. Response: hit=1, hit_way=4'b0100, victim_way=0.
- Same cycle: fill idx=5 way=0 tag=0x11 and lookup idx=5 tag=0x11. Response: hit=0. A lookup one cycle later gives hit=1, hit_way=4'b0001.
- Fill ways 0..3 of set 1 with tags 0x10..0x13, then hit way 0. With HIT_LRU_EN: victim_way=1. Without it: victim_way=0.
- Fill several sets, then pulse flush. busy=1 for 16 cycles; a lookup during busy gives hit_valid=0 next cycle; afterwards all lookups miss and victim_way=0.
- Assert rst_n=0 at flush cycle 5, then release. busy=0, all lookups miss, outputs at reset values.
